// File: rtl/bp_fe_cmd_arbiter_pkg.sv
// Shared types for the BE->FE command path: opcode enum, FE command layout,
// and the default attaboy buffer depth.
package bp_fe_cmd_arbiter_pkg;

  localparam int attaboy_els_lp  = 4;
  localparam int vaddr_width_lp  = 39;
  localparam int cmd_meta_width_lp = 8;

  typedef enum logic [3:0] {
    e_op_state_reset          = 4'd0,
    e_op_pc_redirection       = 4'd1,
    e_op_icache_fill_response = 4'd2,
    e_op_icache_fence         = 4'd3,
    e_op_attaboy              = 4'd4,
    e_op_wait                 = 4'd5,
    e_op_icache_fill_restart  = 4'd6,
    e_op_itlb_fill_response   = 4'd7,
    e_op_itlb_fence           = 4'd8
  } bp_fe_command_queue_opcodes_e;

  typedef struct packed {
    bp_fe_command_queue_opcodes_e  opcode;
    logic [vaddr_width_lp-1:0]     npc;
    logic                          taken;
    logic [cmd_meta_width_lp-1:0]  meta;
  } bp_fe_cmd_s;

  localparam int fe_cmd_width_lp = $bits(bp_fe_cmd_s);

  // Commands that make every buffered branch-training update stale.
  function automatic logic is_flush_op(input bp_fe_command_queue_opcodes_e op);
    return (op == e_op_pc_redirection) || (op == e_op_state_reset);
  endfunction

endpackage

// File: rtl/bp_fe_cmd_attaboy_fifo.sv
// Register-based 1r1w FIFO for attaboy commands with a synchronous clear that
// reports whether any live entry (other than a same-cycle dequeue) was dropped.
module bp_fe_cmd_attaboy_fifo
  import bp_fe_cmd_arbiter_pkg::*;
#(
  parameter int els_p   = attaboy_els_lp,
  parameter int width_p = fe_cmd_width_lp
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               full_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic               empty_o,
  output logic               discard_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] rptr_r, wptr_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic                enq, deq;

  assign full_o  = (cnt_r == cnt_w_lp'(els_p));
  assign empty_o = (cnt_r == '0);
  assign enq     = v_i & ~full_o;
  assign deq     = yumi_i & ~empty_o;
  assign data_o  = mem_r[rptr_r];

  // A dequeued head counts as consumed; an entry landing this cycle counts as dropped.
  assign discard_o = clear_i & ((cnt_r != cnt_w_lp'(deq)) | enq);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
      cnt_r  <= '0;
    end else if (clear_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (enq) wptr_r <= wptr_r + ptr_w_lp'(1);
      if (deq) rptr_r <= rptr_r + ptr_w_lp'(1);
      cnt_r <= cnt_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_fe_cmd_arbiter.sv
// Merges the non-attaboy command stream and the buffered attaboy stream onto the
// single FE command channel; non-attaboy commands win and are held until consumed.
module bp_fe_cmd_arbiter
  import bp_fe_cmd_arbiter_pkg::*;
#(
  parameter int attaboy_els_p = attaboy_els_lp
) (
  input  logic       clk_i,
  input  logic       reset_n_i,

  input  bp_fe_cmd_s cmd_i,
  input  logic       cmd_v_i,
  output logic       cmd_ready_and_o,

  input  bp_fe_cmd_s attaboy_i,
  input  logic       attaboy_v_i,
  output logic       attaboy_ready_and_o,

  output bp_fe_cmd_s fe_cmd_o,
  output logic       fe_cmd_v_o,
  input  logic       fe_cmd_yumi_i,

  output logic       attaboy_flush_o,
  output logic       empty_o
);

  // Handshakes: inputs transfer on valid & ready_and; ready never depends on the
  // same-cycle valid or on fe_cmd_yumi_i. The FE yumi may only be raised while
  // fe_cmd_v_o is high and consumes whatever is presented that cycle.

  bp_fe_cmd_s                 cmd_r;
  logic                       cmd_v_r;
  logic                       flush_r;
  logic                       cmd_accept, cmd_deq, fifo_yumi, flush;
  logic                       fifo_full, fifo_empty, fifo_discard;
  logic [fe_cmd_width_lp-1:0] fifo_data;

  assign cmd_ready_and_o = ~cmd_v_r;
  assign cmd_accept      = cmd_v_i & ~cmd_v_r;
  assign cmd_deq         = fe_cmd_yumi_i & cmd_v_r;
  assign fifo_yumi       = fe_cmd_yumi_i & ~cmd_v_r;
  assign flush           = cmd_accept & is_flush_op(cmd_i.opcode);

  bp_fe_cmd_attaboy_fifo #(
    .els_p   (attaboy_els_p),
    .width_p (fe_cmd_width_lp)
  ) attaboy_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (flush),
    .data_i    (attaboy_i),
    .v_i       (attaboy_v_i),
    .full_o    (fifo_full),
    .yumi_i    (fifo_yumi),
    .data_o    (fifo_data),
    .empty_o   (fifo_empty),
    .discard_o (fifo_discard)
  );

  assign attaboy_ready_and_o = ~fifo_full;
  assign fe_cmd_v_o          = cmd_v_r | ~fifo_empty;
  assign empty_o             = ~cmd_v_r & fifo_empty;
  assign attaboy_flush_o     = flush_r;

  always_comb begin
    fe_cmd_o = bp_fe_cmd_s'(fifo_data);
    if (cmd_v_r) fe_cmd_o = cmd_r;
  end

  // The slot only refills from empty, so a presented command is frozen until yumi.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_r   <= '0;
      cmd_v_r <= 1'b0;
      flush_r <= 1'b0;
    end else begin
      if (cmd_accept) begin
        cmd_r   <= cmd_i;
        cmd_v_r <= 1'b1;
      end else if (cmd_deq) begin
        cmd_v_r <= 1'b0;
      end
      flush_r <= fifo_discard;
    end
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fe_cmd_yumi_i |-> fe_cmd_v_o);
  a_cmd_not_attaboy: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    cmd_v_i |-> (cmd_i.opcode != e_op_attaboy));
  a_attaboy_is_attaboy: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    attaboy_v_i |-> (attaboy_i.opcode == e_op_attaboy));

endmodule

// File: tb/tb_bp_fe_cmd_arbiter.sv
// Self-checking bench for bp_fe_cmd_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_bp_fe_cmd_arbiter;
  import bp_fe_cmd_arbiter_pkg::*;

  localparam int ELS = 4;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  bp_fe_cmd_s cmd_i = '0;
  logic       cmd_v_i = 1'b0;
  logic       cmd_ready_and_o;
  bp_fe_cmd_s attaboy_i = '0;
  logic       attaboy_v_i = 1'b0;
  logic       attaboy_ready_and_o;
  bp_fe_cmd_s fe_cmd_o;
  logic       fe_cmd_v_o;
  logic       fe_cmd_yumi_i = 1'b0;
  logic       attaboy_flush_o;
  logic       empty_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        check_en = 1'b0;

  bp_fe_cmd_arbiter #(.attaboy_els_p(ELS)) dut (
    .clk_i               (clk_i),
    .reset_n_i           (reset_n_i),
    .cmd_i               (cmd_i),
    .cmd_v_i             (cmd_v_i),
    .cmd_ready_and_o     (cmd_ready_and_o),
    .attaboy_i           (attaboy_i),
    .attaboy_v_i         (attaboy_v_i),
    .attaboy_ready_and_o (attaboy_ready_and_o),
    .fe_cmd_o            (fe_cmd_o),
    .fe_cmd_v_o          (fe_cmd_v_o),
    .fe_cmd_yumi_i       (fe_cmd_yumi_i),
    .attaboy_flush_o     (attaboy_flush_o),
    .empty_o             (empty_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  bp_fe_cmd_s cmd_q[$];
  bp_fe_cmd_s atb_q[$];
  logic       flush_exp = 1'b0;

  function automatic logic exp_v();
    return (cmd_q.size() != 0) || (atb_q.size() != 0);
  endfunction

  function automatic bp_fe_cmd_s exp_cmd();
    if (cmd_q.size() != 0) return cmd_q[0];
    if (atb_q.size() != 0) return atb_q[0];
    return '0;
  endfunction

  initial begin
    int  nc, na;
    bit  acc_c, acc_a, fl;
    forever begin
      @(posedge clk_i or negedge reset_n_i);
      if (!reset_n_i) begin
        cmd_q.delete();
        atb_q.delete();
        flush_exp = 1'b0;
      end else begin
        nc    = cmd_q.size();
        na    = atb_q.size();
        acc_c = cmd_v_i && (nc == 0);
        acc_a = attaboy_v_i && (na < ELS);
        if (fe_cmd_yumi_i) begin
          if (nc != 0) void'(cmd_q.pop_front());
          else if (na != 0) void'(atb_q.pop_front());
        end
        fl = acc_c && (cmd_i.opcode == e_op_pc_redirection || cmd_i.opcode == e_op_state_reset);
        if (fl) begin
          flush_exp = (atb_q.size() != 0) || acc_a;
          atb_q.delete();
        end else begin
          flush_exp = 1'b0;
          if (acc_a) atb_q.push_back(attaboy_i);
        end
        if (acc_c) cmd_q.push_back(cmd_i);
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("fe_cmd_v", 64'(fe_cmd_v_o), 64'(exp_v()));
    if (exp_v()) chk("fe_cmd", 64'(fe_cmd_o), 64'(exp_cmd()));
    chk("cmd_ready", 64'(cmd_ready_and_o), 64'(cmd_q.size() == 0));
    chk("atb_ready", 64'(attaboy_ready_and_o), 64'(atb_q.size() < ELS));
    chk("flush", 64'(attaboy_flush_o), 64'(flush_exp));
    chk("empty", 64'(empty_o), 64'(!exp_v()));
  endtask

  always @(negedge clk_i) if (check_en) compare_all();

  // ---------------- driver ----------------
  function automatic bp_fe_cmd_s mk(input bp_fe_command_queue_opcodes_e op,
                                    input logic [38:0] npc, input logic taken,
                                    input logic [7:0] meta);
    bp_fe_cmd_s c;
    c.opcode = op;
    c.npc    = npc;
    c.taken  = taken;
    c.meta   = meta;
    return c;
  endfunction

  task automatic drive(input logic cv, input bp_fe_cmd_s c, input logic av,
                       input bp_fe_cmd_s a, input logic y);
    cmd_v_i       = cv;
    cmd_i         = c;
    attaboy_v_i   = av;
    attaboy_i     = a;
    fe_cmd_yumi_i = y;
    @(negedge clk_i);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, mk(e_op_attaboy, '0, 1'b0, '0), 1'b0);
  endtask

  task automatic yumi();
    drive(1'b0, '0, 1'b0, mk(e_op_attaboy, '0, 1'b0, '0), 1'b1);
  endtask

  task automatic push_atb(input bp_fe_cmd_s a);
    drive(1'b0, '0, 1'b1, a, 1'b0);
  endtask

  task automatic push_cmd(input bp_fe_cmd_s c, input logic y);
    drive(1'b1, c, 1'b0, mk(e_op_attaboy, '0, 1'b0, '0), y);
  endtask

  // ---------------- stimulus ----------------
  bp_fe_cmd_s a_q[5];
  bp_fe_cmd_s fence_c, redir_c, wait_c;
  bp_fe_command_queue_opcodes_e legal_ops[6];

  initial begin
    for (int i = 0; i < 5; i++)
      a_q[i] = mk(e_op_attaboy, 39'h8000_0040 + 39'(i * 4), 1'b1, 8'(8'hA0 + i));
    fence_c = mk(e_op_icache_fence, 39'h0, 1'b0, 8'h11);
    redir_c = mk(e_op_pc_redirection, 39'h8000_1000, 1'b0, 8'h22);
    wait_c  = mk(e_op_wait, 39'h0, 1'b0, 8'h33);
    legal_ops = '{e_op_state_reset, e_op_pc_redirection, e_op_icache_fill_response,
                  e_op_icache_fence, e_op_wait, e_op_itlb_fence};

    // reset values
    @(negedge clk_i);
    chk("rst_v", 64'(fe_cmd_v_o), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready_and_o), 64'd1);
    chk("rst_atb_ready", 64'(attaboy_ready_and_o), 64'd1);
    chk("rst_flush", 64'(attaboy_flush_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    check_en  = 1'b1;
    idle();

    // single attaboy
    push_atb(a_q[0]);
    chk("t1_v", 64'(fe_cmd_v_o), 64'd1);
    chk("t1_cmd", 64'(fe_cmd_o), 64'(mk(e_op_attaboy, 39'h8000_0040, 1'b1, 8'hA0)));
    chk("t1_empty", 64'(empty_o), 64'd0);
    yumi();
    chk("t1_v_after", 64'(fe_cmd_v_o), 64'd0);
    chk("t1_empty_after", 64'(empty_o), 64'd1);

    // fill FIFO, 5th stalls until one yumi
    for (int i = 0; i < 4; i++) begin
      push_atb(a_q[i]);
      chk("t2_ready_fill", 64'(attaboy_ready_and_o), 64'(i < 3));
    end
    push_atb(a_q[4]);
    chk("t2_ready_stall", 64'(attaboy_ready_and_o), 64'd0);
    chk("t2_head", 64'(fe_cmd_o), 64'(a_q[0]));
    drive(1'b0, '0, 1'b1, a_q[4], 1'b1);
    chk("t2_ready_after_yumi", 64'(attaboy_ready_and_o), 64'd1);
    chk("t2_head2", 64'(fe_cmd_o), 64'(a_q[1]));
    push_atb(a_q[4]);
    chk("t2_ready_full_again", 64'(attaboy_ready_and_o), 64'd0);
    repeat (4) yumi();
    chk("t2_drained", 64'(empty_o), 64'd1);

    // fence preempts queued attaboys, no flush
    push_atb(a_q[0]);
    push_atb(a_q[1]);
    push_cmd(fence_c, 1'b0);
    chk("t3_fence", 64'(fe_cmd_o), 64'(fence_c));
    chk("t3_cmd_ready", 64'(cmd_ready_and_o), 64'd0);
    repeat (3) begin
      idle();
      chk("t3_fence_held", 64'(fe_cmd_o), 64'(fence_c));
    end
    yumi();
    chk("t3_head_back", 64'(fe_cmd_o), 64'(a_q[0]));
    chk("t3_no_flush", 64'(attaboy_flush_o), 64'd0);
    repeat (2) yumi();

    // redirect + enqueue + head yumi in one cycle
    for (int i = 0; i < 3; i++) push_atb(a_q[i]);
    drive(1'b1, redir_c, 1'b1, a_q[3], 1'b1);
    chk("t4_flush", 64'(attaboy_flush_o), 64'd1);
    chk("t4_redir", 64'(fe_cmd_o), 64'(mk(e_op_pc_redirection, 39'h8000_1000, 1'b0, 8'h22)));
    chk("t4_atb_ready", 64'(attaboy_ready_and_o), 64'd1);

    // held redirect blocks the next command until yumi
    push_cmd(wait_c, 1'b0);
    chk("t5_flush_pulse_end", 64'(attaboy_flush_o), 64'd0);
    chk("t5_cmd_ready", 64'(cmd_ready_and_o), 64'd0);
    chk("t5_redir_held", 64'(fe_cmd_o), 64'(redir_c));
    push_cmd(wait_c, 1'b1);
    chk("t5_cmd_ready_after", 64'(cmd_ready_and_o), 64'd1);
    chk("t5_v_gap", 64'(fe_cmd_v_o), 64'd0);
    push_cmd(wait_c, 1'b0);
    chk("t5_wait", 64'(fe_cmd_o), 64'(wait_c));
    yumi();

    // flush of a full FIFO reopens it after the flush edge
    for (int i = 0; i < 4; i++) push_atb(a_q[i]);
    drive(1'b1, mk(e_op_state_reset, '0, 1'b0, 8'h44), 1'b1, a_q[4], 1'b0);
    chk("t6_flush", 64'(attaboy_flush_o), 64'd1);
    chk("t6_atb_ready", 64'(attaboy_ready_and_o), 64'd1);
    yumi();
    chk("t6_empty", 64'(empty_o), 64'd1);

    // asynchronous reset mid-stream
    push_atb(a_q[0]);
    push_atb(a_q[1]);
    push_cmd(fence_c, 1'b0);
    idle();
    #2 reset_n_i = 1'b0;
    #1;
    chk("t7_v", 64'(fe_cmd_v_o), 64'd0);
    chk("t7_cmd_ready", 64'(cmd_ready_and_o), 64'd1);
    chk("t7_atb_ready", 64'(attaboy_ready_and_o), 64'd1);
    chk("t7_flush", 64'(attaboy_flush_o), 64'd0);
    chk("t7_empty", 64'(empty_o), 64'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    idle();
    idle();
    chk("t7_empty_after", 64'(empty_o), 64'd1);
    chk("t7_v_after", 64'(fe_cmd_v_o), 64'd0);

    // randomized traffic in phases of differing yumi pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 500; n++) begin
        logic       cv, av, y;
        bp_fe_cmd_s c, a;
        cv = ($urandom_range(0, 5) == 0);
        c  = mk(legal_ops[$urandom_range(0, 5)], 39'($urandom), 1'($urandom), 8'($urandom));
        av = ($urandom_range(0, 2) != 0);
        a  = mk(e_op_attaboy, 39'($urandom), 1'($urandom), 8'($urandom));
        y  = exp_v() && ($urandom_range(0, 3) < ph + 1);
        drive(cv, c, av, a, y);
      end
    end
    idle();
    check_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
